// File: rtl/ecc_encode_pipe_if.sv
// -----------------------------------------------------------------------------
// ecc_encode_pipe_if
//
// Purpose: bundles the upstream word handshake (with its per-word injection
// controls) and the downstream codeword handshake of ecc_encode_pipe.
//
// Signals:
//   s_valid / s_ready   upstream handshake
//   s_data   [DW]       raw data word
//   inj_mode [2]        00 none, 01 single flip, 10 double flip, 11 none
//   inj_pos0 [PIW]      first codeword bit index to flip
//   inj_pos1 [PIW]      second codeword bit index to flip (mode 10 only)
//   m_valid / m_ready   downstream handshake
//   m_data   [CW]       SECDED codeword
//
// Modports:
//   slave  - the encoder (consumes s_*, produces m_*)
//   master - the environment driving the encoder
// -----------------------------------------------------------------------------
interface ecc_encode_pipe_if #(
   parameter int DW = 64
);
   localparam int PW  = $clog2(1 + DW + $clog2(1 + DW));
   localparam int CW  = DW + PW + 1;
   localparam int PIW = $clog2(CW);

   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_data;
   logic [1:0]      inj_mode;
   logic [PIW-1:0]  inj_pos0;
   logic [PIW-1:0]  inj_pos1;
   logic            m_valid;
   logic            m_ready;
   logic [CW-1:0]   m_data;

   modport slave (
      input  s_valid, s_data, inj_mode, inj_pos0, inj_pos1, m_ready,
      output s_ready, m_valid, m_data
   );

   modport master (
      output s_valid, s_data, inj_mode, inj_pos0, inj_pos1, m_ready,
      input  s_ready, m_valid, m_data
   );
endinterface

// File: rtl/ecc_encode_pipe.sv
// -----------------------------------------------------------------------------
// ecc_encode_pipe
//
// Purpose: two-stage pipelined Hamming SECDED encoder with valid/ready on both
// sides and optional per-word bit-flip injection. Produces the codeword format
// consumed by ecc_decode:
//   - Hamming positions are 1-based, position p lives at bit p-1
//   - power-of-two positions carry parity, data fills the rest in ascending
//     order starting with s_data[0]
//   - the top bit is the XOR of all lower bits (even overall parity)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       ecc_encode_pipe_if.slave (s_* word in, m_* codeword out)
//   word_cnt  codewords delivered, saturating
//   inj_cnt   delivered codewords carrying at least one applied flip, saturating
//
// Pipeline:
//   S1 registers the data word, its Hamming parity and the injection controls.
//   S2 forms the overall parity, applies the flips and registers m_data.
//   A stage loads when empty or when its contents move on in the same cycle,
//   which gives full throughput and a combinational m_ready -> s_ready path.
// -----------------------------------------------------------------------------
module ecc_encode_pipe #(
   parameter int DW    = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   ecc_encode_pipe_if.slave bus,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] inj_cnt
);

   localparam int PW  = $clog2(1 + DW + $clog2(1 + DW));
   localparam int HW  = DW + PW;          // Hamming part, without overall parity
   localparam int CW  = HW + 1;
   localparam int PIW = $clog2(CW);

   // Highest valid flip index; anything above it is silently ignored.
   localparam logic [PIW-1:0] POS_MAX = PIW'(CW - 1);

   // 1-based Hamming position of data bit k (k-th non-power-of-two position).
   function automatic int data_pos(input int k);
      int res;
      int cnt;
      res = 0;
      cnt = 0;
      for (int q = 1; q <= HW; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (cnt == k) res = q;
            cnt++;
         end
      end
      return res;
   endfunction

   // Bits covered by parity i: every position whose index has bit i set.
   // Parity slots themselves are zero when this mask is applied, so they
   // never contribute.
   function automatic logic [HW-1:0] cover_mask(input int i);
      logic [HW-1:0] m;
      m = '0;
      for (int q = 1; q <= HW; q++) begin
         if (((q >> i) & 1) != 0) m[q-1] = 1'b1;
      end
      return m;
   endfunction

   // ------------------------------------------------------------------
   // Handshake / stage advance
   // ------------------------------------------------------------------
   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic ld1, ld2, accept, deliver;

   assign ld2     = ~v2_q | bus.m_ready;
   assign ld1     = ~v1_q | ld2;
   assign accept  = bus.s_valid & ld1;
   assign deliver = v2_q & bus.m_ready;

   assign bus.s_ready = ld1;
   assign bus.m_valid = v2_q;

   // ------------------------------------------------------------------
   // S1 input side: scatter data into Hamming positions, compute parity
   // ------------------------------------------------------------------
   logic [HW-1:0] ham_in;
   logic [PW-1:0] par_in;

   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_place_in
         localparam int POS = data_pos(gi);
         assign ham_in[POS-1] = bus.s_data[gi];
      end
      for (gi = 0; gi < PW; gi++) begin : g_zero_in
         assign ham_in[(1 << gi) - 1] = 1'b0;
      end
      for (gi = 0; gi < PW; gi++) begin : g_par_in
         localparam logic [HW-1:0] MASK = cover_mask(gi);
         assign par_in[gi] = ^(ham_in & MASK);
      end
   endgenerate

   // ------------------------------------------------------------------
   // S1 registers
   // ------------------------------------------------------------------
   logic [DW-1:0]  d1_q,        d1_d;
   logic [PW-1:0]  par1_q,      par1_d;
   logic [1:0]     inj_mode1_q, inj_mode1_d;
   logic [PIW-1:0] inj_pos0_1_q, inj_pos0_1_d;
   logic [PIW-1:0] inj_pos1_1_q, inj_pos1_1_d;

   // ------------------------------------------------------------------
   // S2 input side: rebuild the Hamming word, add overall parity, inject
   // ------------------------------------------------------------------
   logic [HW-1:0] ham1;
   logic [CW-1:0] cw_clean;
   logic [CW-1:0] flip_mask;
   logic [CW-1:0] cw_inj;
   logic          inj_hit;

   generate
      for (gi = 0; gi < DW; gi++) begin : g_place_s1
         localparam int POS = data_pos(gi);
         assign ham1[POS-1] = d1_q[gi];
      end
      for (gi = 0; gi < PW; gi++) begin : g_par_s1
         assign ham1[(1 << gi) - 1] = par1_q[gi];
      end
   endgenerate

   // Overall parity is formed on the clean word, so injected flips show up
   // as genuine parity errors at the decoder.
   assign cw_clean = {^ham1, ham1};

   // Flips are OR-ed into one mask: equal positions collapse to one flip.
   always_comb begin
      flip_mask = '0;
      case (inj_mode1_q)
         2'b01: begin
            if (inj_pos0_1_q <= POS_MAX) flip_mask = flip_mask | (CW'(1) << inj_pos0_1_q);
         end
         2'b10: begin
            if (inj_pos0_1_q <= POS_MAX) flip_mask = flip_mask | (CW'(1) << inj_pos0_1_q);
            if (inj_pos1_1_q <= POS_MAX) flip_mask = flip_mask | (CW'(1) << inj_pos1_1_q);
         end
         default: flip_mask = '0;
      endcase
   end

   assign cw_inj  = cw_clean ^ flip_mask;
   assign inj_hit = |flip_mask;

   // ------------------------------------------------------------------
   // S2 registers and counters
   // ------------------------------------------------------------------
   logic [CW-1:0]    m_data_q,   m_data_d;
   logic             inj2_q,     inj2_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] inj_cnt_q,  inj_cnt_d;

   assign bus.m_data = m_data_q;
   assign word_cnt   = word_cnt_q;
   assign inj_cnt    = inj_cnt_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      v1_d         = v1_q;
      d1_d         = d1_q;
      par1_d       = par1_q;
      inj_mode1_d  = inj_mode1_q;
      inj_pos0_1_d = inj_pos0_1_q;
      inj_pos1_1_d = inj_pos1_1_q;
      v2_d         = v2_q;
      m_data_d     = m_data_q;
      inj2_d       = inj2_q;
      word_cnt_d   = word_cnt_q;
      inj_cnt_d    = inj_cnt_q;

      // S1: inputs are captured only on an actual handshake.
      if (ld1) begin
         v1_d = accept;
         if (accept) begin
            d1_d         = bus.s_data;
            par1_d       = par_in;
            inj_mode1_d  = bus.inj_mode;
            inj_pos0_1_d = bus.inj_pos0;
            inj_pos1_1_d = bus.inj_pos1;
         end
      end

      // S2: m_data only changes when a new word moves in, so it is held
      // stable while the output is stalled.
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            m_data_d = cw_inj;
            inj2_d   = inj_hit;
         end
      end

      if (deliver) begin
         if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
         if (inj2_q && (inj_cnt_q != '1)) inj_cnt_d = inj_cnt_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q         <= 1'b0;
         d1_q         <= '0;
         par1_q       <= '0;
         inj_mode1_q  <= '0;
         inj_pos0_1_q <= '0;
         inj_pos1_1_q <= '0;
         v2_q         <= 1'b0;
         m_data_q     <= '0;
         inj2_q       <= 1'b0;
         word_cnt_q   <= '0;
         inj_cnt_q    <= '0;
      end else begin
         v1_q         <= v1_d;
         d1_q         <= d1_d;
         par1_q       <= par1_d;
         inj_mode1_q  <= inj_mode1_d;
         inj_pos0_1_q <= inj_pos0_1_d;
         inj_pos1_1_q <= inj_pos1_1_d;
         v2_q         <= v2_d;
         m_data_q     <= m_data_d;
         inj2_q       <= inj2_d;
         word_cnt_q   <= word_cnt_d;
         inj_cnt_q    <= inj_cnt_d;
      end
   end

endmodule

// File: doc/ecc_encode_pipe.md
Name: ecc_encode_pipe

Overview:
- Pipelined Hamming SECDED encoder with valid/ready handshakes on both sides.
- Produces the exact codeword format consumed by ecc_decode. Sits on the write path of ECC-protected FIFO/DPRAM storage.
- Optional per-word error injection (single or double bit flips) for exercising the decode side in simulation and bring-up.
- Keeps word and injection counters for debug.

Parameters:
- DW, 64, data width in bits.
- PW, $clog2(1+DW+$clog2(1+DW)), number of Hamming parity bits. Codeword width is DW+PW+1.
- CNT_W, 32, width of the debug counters.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  encoder can accept a word.
- s_data  input  DW  raw data word.
- inj_mode  input  2  injection mode: 00 none, 01 single flip, 10 double flip, 11 none (reserved).
- inj_pos0  input  $clog2(DW+PW+1)  first codeword bit index to flip.
- inj_pos1  input  $clog2(DW+PW+1)  second codeword bit index to flip (mode 10 only).
- m_valid  output  1  codeword valid.
- m_ready  input  1  downstream accepts the codeword.
- m_data  output  DW+PW+1  encoded codeword [DW+PW:0].
- word_cnt  output  CNT_W  codewords delivered (m_valid & m_ready); saturates at all-ones.
- inj_cnt  output  CNT_W  delivered codewords that had at least one bit flipped; saturates.

Behaviour:
Codeword layout:
- Hamming positions are 1-based; position p maps to bit p-1.
- Power-of-two positions (bits 0,1,3,7,15,31,63 for DW=64) hold parity bits.
- Data bits fill the non-power-of-two positions in ascending order, s_data[0] first. For DW=64, s_data[0] is at bit 2.
- Parity bit at position 2^i = XOR of all data-holding positions p with (p & 2^i) != 0.
- Bit DW+PW = XOR of bits [DW+PW-1:0], giving even overall parity.

Pipeline:
- Two register stages, S1 and S2. Latency is 2 cycles from input handshake to m_valid with m_ready held high.
- S1 registers s_data, the computed Hamming parity bits, and the injection controls.
- S2 computes the overall parity bit, applies injection after overall parity is formed, and registers m_data.
- Stage advance rule: a stage loads when it is empty or when its contents move downstream that cycle.
- s_ready = ~v1 | ~v2 | m_ready. This is a combinational path from m_ready.
- Throughput is 1 word/cycle with no bubbles under continuous m_ready.
- When m_valid is high and m_ready is low, m_data is held stable and m_valid stays high (AXI-stream rule).
- Words are never dropped, duplicated, or reordered.
- s_data and the inj_* inputs are sampled only on s_valid & s_ready.

Injection:
- Mode 01: flip bit inj_pos0.
- Mode 10: flip bits inj_pos0 and inj_pos1. If they are equal, only a single flip is applied.
- Any position > DW+PW is ignored (that flip is not applied).
- inj_cnt increments only if at least one flip was actually applied.

Reset:
- v1, v2, m_valid, word_cnt, inj_cnt = 0. m_data = 0. S1 data registers = 0. s_ready = 1 after reset.
- Reset mid-stream discards all in-flight words.
- m_valid falls asynchronously with rst_n assertion.

Counters:
- Both counters update on the same edge as the m handshake.

Test Plan:
1. s_data=0, inj_mode=00, m_ready=1 -> m_data=72'h0 two cycles after accept; word_cnt=1, inj_cnt=0.
2. s_data=64'h1, inj_mode=00 -> m_data=72'h80_0000_0000_0000_0007. Feeding it to ecc_decode gives data_o=1, sbiterr=0, dbiterr=0.
3. Stream 1000 random words through ecc_decode, with injection as follows:
   - inj_mode=00 -> data_o matches input, no error flags.
   - inj_mode=01, random inj_pos0 in 0..70 -> data_o matches input, sbiterr=1.
   - inj_mode=10, distinct positions in 0..70 -> dbiterr=1.
   - inj_cnt counts exactly the words in the 01 and 10 cases.
4. Boundary injection cases:
   - inj_mode=10 with inj_pos0=inj_pos1=5 -> exactly bit 5 flipped.
   - inj_pos0=100 -> no flip, inj_cnt unchanged.
5. Back-to-back s_valid, m_ready low for cycles 3-5:
   - s_ready drops after 2 words are buffered.
   - m_data stays stable while stalled.
   - Words exit in order with no loss; after release, 1 word/cycle resumes.
6. rst_n asserted while 2 words are in flight -> m_valid=0 immediately, counters=0. After release, the next accepted word appears at latency 2.
